id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
Parametrised decode stage for the 5-stage MIPS pipeline, sitting between IF and EX.
- Integrated register file with write-through bypass.
- N-source priority forwarding and early branch resolution on the forwarded operands.
- Load-use stall detection.
- Registered ID/EX pipeline register with valid/ready handshake and flush.

Parameters:
XLEN, 32, datapath and register width
RA_W, 5, register address width; 2**RA_W registers, register 0 hardwired to zero
NFWD, 2, number of forwarding sources; index 0 = youngest stage (EX/MEM), highest priority

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  IF/ID holds a valid instruction
in_ready  out  1  ID accepts the instruction this cycle
in_pc  in  XLEN  instruction PC
in_instr  in  32  instruction word
in_ext_zero  in  1  1 = zero-extend imm, 0 = sign-extend
in_br_type  in  2  00 none, 01 beq, 10 bne, 11 reserved (never taken)
wb_en  in  1  register write enable
wb_addr  in  RA_W  write address
wb_data  in  XLEN  write data
fwd_valid  in  NFWD  per-source forward valid
fwd_addr  in  NFWD*RA_W  per-source destination, source i at [i*RA_W +: RA_W]
fwd_data  in  NFWD*XLEN  per-source data
ex_is_load  in  1  instruction currently in EX is a load
ex_rd  in  RA_W  destination of that load
flush  in  1  kill the ID/EX contents and the current ID instruction
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX accepts
out_pc, out_instr  out  XLEN, 32  registered pass-through
out_rs_data, out_rt_data  out  XLEN  registered forwarded operands
out_imm  out  XLEN  registered extended immediate
br_taken  out  1  combinational branch decision
br_target  out  XLEN  in_pc + 4 + (ext_imm << 2)
stall_count  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (reset low, asynchronous): all register-file entries = 0; out_valid = 0; out_pc, out_instr, out_rs_data, out_rt_data and out_imm = 0; stall_count = 0.
- rs = instr[25:21], rt = instr[20:16]; imm = instr[15:0], extended per in_ext_zero.
- Operand selection, per operand, priority order:
  1. addr == 0 -> 0.
  2. Lowest-index fwd_valid[i] with fwd_addr[i] == addr -> fwd_data[i].
  3. wb_en && wb_addr == addr -> wb_data (same-cycle write-through).
  4. Otherwise the register-file value.
- Register-file write on the rising edge when wb_en && wb_addr != 0; writes to register 0 are ignored.
- load_use = in_valid && ex_is_load && ex_rd != 0 && (ex_rd == rs || ex_rd == rt). Both operands are always treated as used.
- in_ready = !load_use && (!out_valid || out_ready) && !flush.
- br_taken = in_valid && !load_use && (beq: rs_val == rt_val | bne: rs_val != rt_val).
- ID/EX update each cycle, precedence flush > load-use bubble > load > hold:
  - flush: out_valid <= 0.
  - else if load_use && (!out_valid || out_ready): out_valid <= 0 (bubble). The instruction stays in IF/ID, and its operands are re-evaluated next cycle.
  - else if in_valid && in_ready: load all out_* with the current values; out_valid <= 1.
  - else if out_valid && out_ready: out_valid <= 0.
  - else: hold, contents stable while !out_ready.
- flush and a same-cycle accept: the instruction is dropped and in_ready = 0. flush and wb_en: the write still occurs.
- Reset asserted mid-operation clears state immediately. First accept is possible on the first clock edge after reset deasserts.
- Latency: one cycle from accept to out_valid.

Optional Feature:
ID_STALL_CNT_EN
- Defined: stall_count increments (wraps at 2**32) on every cycle with load_use || (out_valid && !out_ready). Cleared by reset; not affected by flush.
- Undefined: stall_count is tied to 0 and no counter flops exist.

Decomposition:
- Shared package holds:
  - localparams for instr field positions (RS_LSB 21, RT_LSB 16, IMM_W 16);
  - branch-type encodings BR_NONE/BR_BEQ/BR_BNE;
  - XLEN default.
- One sub-module, id_regfile (parametrised XLEN/RA_W, 2 read ports, 1 write port, async reset, internal write-through bypass).
- Forwarding priority mux and ID/EX register live in the top.

Test Plan:
- Write r5=0x1234 via WB, then `add` reading rs=5 the next cycle -> out_rs_data=0x1234 one cycle after accept.
- Same cycle: wb r3=0xAAAA, fwd[1] r3=0xBBBB, fwd[0] r3=0xCCCC -> operand 0xCCCC. Drop fwd[0] -> 0xBBBB. Drop both -> 0xAAAA.
- ex_is_load=1, ex_rd=8, instr rs=8 -> in_ready=0, out_valid=0 for exactly one cycle. Next cycle, with the load moved on, the instruction is accepted with forwarded data.
- beq r1=r2=7, pc=0x3000, imm=0xFFFF -> br_taken=1, br_target=0x3000. bne same operands -> br_taken=0.
- out_ready held 0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0. Assert flush -> out_valid=0 next cycle. With ID_STALL_CNT_EN, stall_count=3 after the hold.
- Write to r0 with 0xFFFF, then read r0 -> 0. Assert reset mid-stream -> out_valid=0 immediately, all registers read 0.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// ============================================================================
// Module      : id_stage_pipe_pkg
// Description : Shared field positions, branch encodings and defaults for the
//               MIPS decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_stage_pipe_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int IMM_W  = 16;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_RSVD = 2'b11
  } br_type_e;

endpackage

`default_nettype wire

// File: rtl/id_regfile.sv
// ============================================================================
// Module      : id_regfile
// Description : 2-read/1-write register file, register 0 reads as zero, with
//               same-cycle write-through to both read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_regfile
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RA_W-1:0] raddr0,
  input  logic [RA_W-1:0] raddr1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1
);

  localparam int c_depth = 2 ** RA_W;

  logic [XLEN-1:0] r_mem [c_depth];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata0 = r_mem[raddr0];
    rdata1 = r_mem[raddr1];
    if (we && (waddr == raddr0)) rdata0 = wdata;
    if (we && (waddr == raddr1)) rdata1 = wdata;
    // Zero check last so a write-through to r0 can never leak out.
    if (raddr0 == '0) rdata0 = '0;
    if (raddr1 == '0) rdata1 = '0;
  end

endmodule

`default_nettype wire

// File: rtl/id_stage_pipe.sv
// ============================================================================
// Module      : id_stage_pipe
// Description : MIPS ID stage: register file, priority forwarding, early branch
//               resolution, load-use stall and registered ID/EX handshake.
//               Optional stall counter enabled by macro ID_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int RA_W = 5,
  parameter int NFWD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  input  logic                 in_ext_zero,
  input  logic [1:0]           in_br_type,
  input  logic                 wb_en,
  input  logic [RA_W-1:0]      wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RA_W-1:0] fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 ex_is_load,
  input  logic [RA_W-1:0]      ex_rd,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      out_rs_data,
  output logic [XLEN-1:0]      out_rt_data,
  output logic [XLEN-1:0]      out_imm,
  output logic                 br_taken,
  output logic [XLEN-1:0]      br_target,
  output logic [31:0]          stall_count
);

  logic [RA_W-1:0]  w_rs, w_rt;
  logic [IMM_W-1:0] w_imm_raw;
  logic [XLEN-1:0]  w_ext_imm;
  logic [XLEN-1:0]  w_rf_rs, w_rf_rt;
  logic [XLEN-1:0]  w_rs_val, w_rt_val;
  logic             w_load_use, w_out_free;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_pc, r_out_rs, r_out_rt, r_out_imm;
  logic [31:0]      r_out_instr;

  assign w_rs      = in_instr[RS_LSB +: RA_W];
  assign w_rt      = in_instr[RT_LSB +: RA_W];
  assign w_imm_raw = in_instr[IMM_W-1:0];
  assign w_ext_imm = in_ext_zero ? {{(XLEN-IMM_W){1'b0}}, w_imm_raw}
                                 : {{(XLEN-IMM_W){w_imm_raw[IMM_W-1]}}, w_imm_raw};

  id_regfile #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr0 (w_rs),
    .raddr1 (w_rt),
    .rdata0 (w_rf_rs),
    .rdata1 (w_rf_rt)
  );

  // Walk oldest to youngest so the lowest-index matching source wins.
  always_comb begin
    w_rs_val = w_rf_rs;
    w_rt_val = w_rf_rt;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_addr[i*RA_W +: RA_W] == w_rs)) w_rs_val = fwd_data[i*XLEN +: XLEN];
      if (fwd_valid[i] && (fwd_addr[i*RA_W +: RA_W] == w_rt)) w_rt_val = fwd_data[i*XLEN +: XLEN];
    end
    if (w_rs == '0) w_rs_val = '0;
    if (w_rt == '0) w_rt_val = '0;
  end

  assign w_load_use = in_valid && ex_is_load && (ex_rd != '0) &&
                      ((ex_rd == w_rs) || (ex_rd == w_rt));
  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = !w_load_use && w_out_free && !flush;

  always_comb begin
    br_taken = 1'b0;
    if (in_valid && !w_load_use) begin
      case (br_type_e'(in_br_type))
        BR_BEQ:  br_taken = (w_rs_val == w_rt_val);
        BR_BNE:  br_taken = (w_rs_val != w_rt_val);
        default: br_taken = 1'b0;
      endcase
    end
  end

  assign br_target = in_pc + XLEN'(4) + (w_ext_imm << 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_out_rs    <= '0;
      r_out_rt    <= '0;
      r_out_imm   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load_use && w_out_free) begin
      r_out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= in_pc;
      r_out_instr <= in_instr;
      r_out_rs    <= w_rs_val;
      r_out_rt    <= w_rt_val;
      r_out_imm   <= w_ext_imm;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_instr   = r_out_instr;
  assign out_rs_data = r_out_rs;
  assign out_rt_data = r_out_rt;
  assign out_imm     = r_out_imm;

`ifdef ID_STALL_CNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_load_use || (r_out_valid && !out_ready)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'd0;
`endif

endmodule

`default_nettype wire
